// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Forwarding select encodings differ between the E-stage ALU path and the D-stage comparator path.
package pipe_hazard_ctrl_pkg;

    // E-stage ALU operand selects
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_W    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    // D-stage comparator operand selects
    localparam logic [1:0] FWD_D_M  = 2'd1;
    localparam logic [1:0] FWD_D_W  = 2'd2;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef enum logic {MD_IDLE, MD_BUSY} mdState_t;

    // Register 0 is hardwired, so it never takes part in a dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// Busy counter for the multi-cycle mult/div unit; a start is only accepted while idle.
module md_busy_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic isDiv,
    output logic mdBusy
);

    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    mdState_t        state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   startLat;

    assign startLat = isDiv ? CW'(DIV_LAT) : CW'(MULT_LAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            mdBusy <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt    <= startLat;
                        state  <= (startLat != '0) ? MD_BUSY : MD_IDLE;
                        mdBusy <= (startLat != '0);
                    end
                end
                MD_BUSY: begin
                    // Starts arriving while busy are dropped, never reloaded.
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= MD_IDLE;
                        mdBusy <= 1'b0;
                    end
                end
                default: begin
                    state  <= MD_IDLE;
                    cnt    <= '0;
                    mdBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage pipeline plus mult/div busy tracking.
// Define HAZ_STATS_EN to add the 32-bit stallCount output.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic       branchD,
    input  logic       mdUseD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       mdStartE,
    input  logic       mdDivE,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic [1:0] ForwardAD,
    output logic [1:0] ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mdBusy
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0] stallCount
`endif
);

    logic mdBusyQ;
    logic loadUse, branchStall, mdStall, stall;

    md_busy_counter #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (mdStartE),
        .isDiv  (mdDivE),
        .mdBusy (mdBusyQ)
    );

    always_comb begin
        loadUse     = ((useRsD && regMatch(rsD, WriteRegE)) ||
                       (useRtD && regMatch(rtD, WriteRegE))) && MemtoRegE && RegWriteE;
        branchStall = branchD &&
                      (((regMatch(rsD, WriteRegE) || regMatch(rtD, WriteRegE)) && RegWriteE) ||
                       ((regMatch(rsD, WriteRegM) || regMatch(rtD, WriteRegM)) && MemtoRegM));
        mdStall     = mdUseD && (mdBusyQ || mdStartE);
        stall       = !reset && (loadUse || branchStall || mdStall);
    end

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    assign mdBusy = mdBusyQ && !reset;

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardAD = FWD_RF;
        ForwardBD = FWD_RF;
        if (!reset) begin
            if (regMatch(rsE, WriteRegM) && RegWriteM)      ForwardAE = FWD_M;
            else if (regMatch(rsE, WriteRegW) && RegWriteW) ForwardAE = FWD_W;
            if (regMatch(rtE, WriteRegM) && RegWriteM)      ForwardBE = FWD_M;
            else if (regMatch(rtE, WriteRegW) && RegWriteW) ForwardBE = FWD_W;
            // A load in M has no data yet, so the comparator cannot take it from M.
            if (regMatch(rsD, WriteRegM) && RegWriteM && !MemtoRegM) ForwardAD = FWD_D_M;
            else if (regMatch(rsD, WriteRegW) && RegWriteW)         ForwardAD = FWD_D_W;
            if (regMatch(rtD, WriteRegM) && RegWriteM && !MemtoRegM) ForwardBD = FWD_D_M;
            else if (regMatch(rtD, WriteRegW) && RegWriteW)         ForwardBD = FWD_D_W;
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)      stallCount <= '0;
        else if (stall) stallCount <= stallCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_pipe_hazard_ctrl;

    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic useRsD, useRtD, branchD, mdUseD;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, mdStartE, mdDivE;
    logic stallF, stallD, flushE, mdBusy;
    logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;
`ifdef HAZ_STATS_EN
    logic [31:0] stallCount;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .branchD(branchD), .mdUseD(mdUseD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .mdStartE(mdStartE), .mdDivE(mdDivE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mdBusy(mdBusy)
`ifdef HAZ_STATS_EN
        , .stallCount(stallCount)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    // Model: the unit is busy for every cycle index <= busyEnd.
    int cyc = 0;
    int busyEnd = -1;
    int unsigned stallCntM = 0;

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic bit mBusy();
        return !reset && (cyc <= busyEnd);
    endfunction

    function automatic bit mStall();
        bit lu, br, md;
        lu = ((useRsD && hit(rsD, WriteRegE)) || (useRtD && hit(rtD, WriteRegE))) && MemtoRegE && RegWriteE;
        br = branchD && (((hit(rsD, WriteRegE) || hit(rtD, WriteRegE)) && RegWriteE) ||
                         ((hit(rsD, WriteRegM) || hit(rtD, WriteRegM)) && MemtoRegM));
        md = mdUseD && ((cyc <= busyEnd) || mdStartE);
        return !reset && (lu || br || md);
    endfunction

    function automatic logic [1:0] mFwdE(input logic [4:0] r);
        if (reset) return 2'd0;
        if (hit(r, WriteRegM) && RegWriteM) return 2'd2;
        if (hit(r, WriteRegW) && RegWriteW) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [1:0] mFwdD(input logic [4:0] r);
        if (reset) return 2'd0;
        if (hit(r, WriteRegM) && RegWriteM && !MemtoRegM) return 2'd1;
        if (hit(r, WriteRegW) && RegWriteW) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            if (busyEnd > cyc) busyEnd = cyc;
            stallCntM = 0;
        end else begin
            if (mStall()) stallCntM = stallCntM + 1;
            if (mdStartE && !(cyc <= busyEnd)) busyEnd = cyc + (mdDivE ? DL : ML);
        end
        cyc = cyc + 1;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp("stallF", {31'd0, stallF}, {31'd0, mStall()});
            cmp("stallD", {31'd0, stallD}, {31'd0, mStall()});
            cmp("flushE", {31'd0, flushE}, {31'd0, mStall()});
            cmp("mdBusy", {31'd0, mdBusy}, {31'd0, mBusy()});
            cmp("ForwardAE", {30'd0, ForwardAE}, {30'd0, mFwdE(rsE)});
            cmp("ForwardBE", {30'd0, ForwardBE}, {30'd0, mFwdE(rtE)});
            cmp("ForwardAD", {30'd0, ForwardAD}, {30'd0, mFwdD(rsD)});
            cmp("ForwardBD", {30'd0, ForwardBD}, {30'd0, mFwdD(rtD)});
`ifdef HAZ_STATS_EN
            cmp("stallCount", stallCount, stallCntM);
`endif
        end
    end

    task automatic idle();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        useRsD = 0; useRtD = 0; branchD = 0; mdUseD = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; mdStartE = 0; mdDivE = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        checking = 1;
        #3;
        cmp("reset_stall", {31'd0, stallF}, 32'd0);
        cmp("reset_busy", {31'd0, mdBusy}, 32'd0);

        // load-use: lw $5 in E, add reads $5 in D
        step();
        reset = 1'b0;
        WriteRegE = 5; RegWriteE = 1; MemtoRegE = 1; rsD = 5; useRsD = 1;
        #3;
        cmp("loaduse_stall", {29'd0, stallF, stallD, flushE}, 32'd7);
        step();
        RegWriteE = 0; MemtoRegE = 0; WriteRegE = 0;
        #3;
        cmp("loaduse_release", {31'd0, stallF}, 32'd0);

        // forwarding priority M over W
        step();
        idle();
        rsE = 8; WriteRegM = 8; RegWriteM = 1; WriteRegW = 8; RegWriteW = 1;
        #3;
        cmp("fwdAE_M", {30'd0, ForwardAE}, 32'd2);
        step();
        RegWriteM = 0;
        #3;
        cmp("fwdAE_W", {30'd0, ForwardAE}, 32'd1);

        // multiply start with mflo waiting in D: start + 5 busy cycles
        step();
        idle();
        mdUseD = 1; mdStartE = 1; mdDivE = 0;
        #3;
        cmp("mult_start_stall", {31'd0, stallF}, 32'd1);
        cmp("mult_start_busy", {31'd0, mdBusy}, 32'd0);
        for (int k = 1; k <= ML; k++) begin
            step();
            mdStartE = 0;
            #3;
            cmp("mult_busy_stall", {30'd0, stallF, mdBusy}, 32'd3);
        end
        step();
        #3;
        cmp("mult_done", {30'd0, stallF, mdBusy}, 32'd0);

        // divide interrupted by reset during its 4th busy cycle
        step();
        mdStartE = 1; mdDivE = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            mdStartE = 0;
            #3;
            cmp("div_busy", {31'd0, mdBusy}, 32'd1);
        end
        step();
        reset = 1'b1;
        #3;
        cmp("div_reset_forced", {30'd0, stallF, mdBusy}, 32'd0);
        step();
        reset = 1'b0;
        #3;
        cmp("div_after_reset", {30'd0, stallF, mdBusy}, 32'd0);

        // register 0 never matches
        step();
        idle();
        WriteRegE = 0; RegWriteE = 1; MemtoRegE = 1; rsD = 0; useRsD = 1;
        WriteRegM = 0; RegWriteM = 1; WriteRegW = 0; RegWriteW = 1;
        #3;
        cmp("reg0_stall", {31'd0, stallF}, 32'd0);
        cmp("reg0_fwd", {24'd0, ForwardAD, ForwardBD, ForwardAE, ForwardBE}, 32'd0);

`ifdef HAZ_STATS_EN
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        WriteRegE = 7; RegWriteE = 1; MemtoRegE = 1; rtD = 7; useRtD = 1;
        step();
        step();
        step();
        idle();
        #3;
        cmp("stats_three", stallCount, 32'd3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #3;
        cmp("stats_reset", stallCount, 32'd0);
`endif

        // randomized traffic with small address range to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            step();
            reset     = ($urandom_range(0, 99) == 0);
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            rsE       = 5'($urandom_range(0, 3));
            rtE       = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3));
            WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            useRsD    = 1'($urandom);
            useRtD    = 1'($urandom);
            branchD   = ($urandom_range(0, 3) == 0);
            mdUseD    = ($urandom_range(0, 2) == 0);
            RegWriteE = 1'($urandom);
            RegWriteM = 1'($urandom);
            RegWriteW = 1'($urandom);
            MemtoRegE = 1'($urandom);
            MemtoRegM = 1'($urandom);
            mdStartE  = ($urandom_range(0, 7) == 0);
            mdDivE    = 1'($urandom);
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
